// File: rtl/spi_master.sv
// spi_master: SPI master with runtime mode, bit order, slave select and clock divider.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module spi_master #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned DIV_W  = 16
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [DATA_W-1:0]                               data_in,
   output logic [DATA_W-1:0]                               data_out,
   input  logic                                            ready_send,
   output logic                                            busy,
   output logic                                            done,
   input  logic                                            cpol,
   input  logic                                            cpha,
   input  logic                                            lsb_first,
   input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0]  ss_sel,
   input  logic [DIV_W-1:0]                                clk_div,
   input  logic                                            miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic                                            loopback,
`endif
   output logic                                            mosi,
   output logic                                            sclk,
   output logic [NUM_SS-1:0]                               ss_n
);

   localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
   localparam int unsigned NEDGE = 2 * DATA_W;
   localparam int unsigned EC_W  = $clog2(NEDGE + 1);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  half_q, half_d;
   logic [EC_W-1:0]   edge_q, edge_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic [SS_W-1:0]   ss_sel_q, ss_sel_d;
   logic              mosi_q, mosi_d;
   logic              sclk_q, sclk_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tick_c;
   logic              sample_c;
   logic              rx_bit_c;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                  input logic b);
      return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
   endfunction

   // Out-of-range indices leave every select deasserted.
   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (sel == SS_W'(i)) v[i] = 1'b0;
      end
      return v;
   endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_bit_c = loopback ? mosi_q : miso;
`else
   assign rx_bit_c = miso;
`endif

   assign tick_c   = (cnt_q == half_q - DIV_W'(1));
   // Leading edges sample when cpha=0, trailing edges sample when cpha=1.
   assign sample_c = (~edge_q[0]) ^ cpha_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_d     = half_q;
      edge_d     = edge_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      data_out_d = data_out_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      ss_sel_d   = ss_sel_q;
      mosi_d     = mosi_q;
      sclk_d     = sclk_q;
      ss_n_d     = ss_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ready_send) begin
               state_d  = LEAD;
               cnt_d    = '0;
               half_d   = (clk_div == '0) ? DIV_W'(1) : clk_div;
               edge_d   = '0;
               cpol_d   = cpol;
               cpha_d   = cpha;
               lsb_d    = lsb_first;
               ss_sel_d = ss_sel;
               rx_d     = '0;
               sclk_d   = cpol;
               busy_d   = 1'b1;
               ss_n_d   = ss_decode(ss_sel);
               if (cpha) begin
                  tx_d = data_in;
               end else begin
                  mosi_d = first_bit(data_in, lsb_first);
                  tx_d   = shift_out(data_in, lsb_first);
               end
            end
         end
         LEAD, XFER: begin
            if (tick_c) begin
               cnt_d   = '0;
               sclk_d  = ~sclk_q;
               edge_d  = edge_q + EC_W'(1);
               state_d = (edge_q == EC_W'(NEDGE - 1)) ? TRAIL : XFER;
               if (sample_c) begin
                  rx_d = shift_in(rx_q, lsb_q, rx_bit_c);
               end else if (edge_q != EC_W'(NEDGE - 1)) begin
                  mosi_d = first_bit(tx_q, lsb_q);
                  tx_d   = shift_out(tx_q, lsb_q);
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         TRAIL: begin
            sclk_d = cpol_q;
            if (tick_c) begin
               state_d    = IDLE;
               cnt_d      = '0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               ss_n_d     = '1;
               data_out_d = rx_q;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         half_q     <= DIV_W'(1);
         edge_q     <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_out_q <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         ss_sel_q   <= '0;
         mosi_q     <= 1'b0;
         sclk_q     <= 1'b0;
         ss_n_q     <= '1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         edge_q     <= edge_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         data_out_q <= data_out_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
         ss_sel_q   <= ss_sel_d;
         mosi_q     <= mosi_d;
         sclk_q     <= sclk_d;
         ss_n_q     <= ss_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign mosi     = mosi_q;
   assign sclk     = sclk_q;
   assign ss_n     = ss_n_q;

endmodule
